// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte stream link from the host loader into program_loader
interface program_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, input byte_ready);
  modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams a little-endian program into word memory, then feeds the CPU
module program_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_start,
  input  logic                   run_start,
  program_loader_if.slave        stream,
  input  logic [15:0]            pc_in,
  output logic [31:0]            instruction,
  output logic                   cpu_rst,
  output logic [15:0]            loaded_words,
  output logic                   overflow
);

  localparam logic [31:0] NOP = 32'hF000_0000;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t      state, next_state;
  logic [17:0] byte_cnt;
  logic [15:0] word_cnt;
  logic [23:0] asm_q;
  logic [31:0] mem [DEPTH];

  logic        fire;
  logic        enter_load;
  logic [15:0] hdr_n;
  logic [1:0]  lane;
  logic        hdr_last;
  logic        pay_last;
  logic        word_done;
  logic        room;

  assign fire       = (state == LOAD) && stream.byte_valid;
  assign enter_load = (state != LOAD) && (next_state == LOAD);
  assign hdr_n      = {stream.byte_data, word_cnt[7:0]};
  // Payload byte index is byte_cnt - 2; only its low two bits select the lane.
  assign lane       = byte_cnt[1:0] - 2'd2;
  assign hdr_last   = (byte_cnt == 18'd1) && (hdr_n == 16'd0);
  assign pay_last   = (byte_cnt >= 18'd2) && (byte_cnt == {word_cnt, 2'b00} + 18'd1);
  assign word_done  = (byte_cnt >= 18'd2) && (lane == 2'd3);
  assign room       = {1'b0, loaded_words} < 17'(DEPTH);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (load_start)     next_state = LOAD;
        else if (run_start) next_state = RUN;
      end
      LOAD: if (fire && (hdr_last || pay_last)) next_state = RUN;
      RUN:  if (load_start) next_state = LOAD;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    stream.byte_ready = (state == LOAD);
    cpu_rst           = (state != RUN);
    instruction       = NOP;
    if (state == RUN && pc_in < loaded_words) instruction = mem[pc_in[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst || enter_load) begin
      byte_cnt     <= '0;
      word_cnt     <= '0;
      asm_q        <= '0;
      loaded_words <= '0;
      overflow     <= 1'b0;
    end else if (fire) begin
      byte_cnt <= byte_cnt + 18'd1;
      if (byte_cnt == 18'd0) begin
        word_cnt[7:0] <= stream.byte_data;
      end else if (byte_cnt == 18'd1) begin
        word_cnt[15:8] <= stream.byte_data;
        overflow       <= {1'b0, hdr_n} > 17'(DEPTH);
      end else begin
        case (lane)
          2'd0:    asm_q[7:0]   <= stream.byte_data;
          2'd1:    asm_q[15:8]  <= stream.byte_data;
          2'd2:    asm_q[23:16] <= stream.byte_data;
          default: if (room) loaded_words <= loaded_words + 16'd1;
        endcase
      end
    end
  end

  // Words are written in order, so loaded_words doubles as the write pointer.
  always_ff @(posedge clk) begin
    if (!rst && fire && word_done && room)
      mem[loaded_words[AW-1:0]] <= {stream.byte_data, asm_q};
  end

endmodule
